// File: rtl/modal_shift_counter_pkg.sv
`default_nettype none
//==============================================================================
// Module      : modal_shift_counter_pkg
// Description : Shared mode encodings, period width and the saturating
//               increment used by the modal shift counter.
// Revision    : 1.0 - initial release
//==============================================================================
package modal_shift_counter_pkg;

    // Step-mode encodings presented on the mode input
    typedef enum logic [1:0] {
        MODE_RING    = 2'b00,
        MODE_JOHNSON = 2'b01,
        MODE_LFSR    = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    // Width of the internal step counter and of the period output
    localparam int PERIOD_W = 16;

    // Increment that sticks at all-ones instead of rolling over
    function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage : modal_shift_counter_pkg
`default_nettype wire

// File: rtl/modal_shift_counter_shift_next_state.sv
`default_nettype none
//==============================================================================
// Module      : shift_next_state
// Description : Pure combinational next-state function for the ring, Johnson
//               and Fibonacci LFSR step modes. Hold returns the current state.
// Revision    : 1.0 - initial release
//==============================================================================
module shift_next_state
    import modal_shift_counter_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b0011)
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [WIDTH-1:0] nxt
);

    // Select the shifted value for the active mode; dir is ignored for LFSR
    always_comb begin
        nxt = cur;
        case (mode_e'(mode))
            MODE_RING: begin
                if (dir) nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
                else     nxt = {cur[0], cur[WIDTH-1:1]};
            end
            MODE_JOHNSON: begin
                if (dir) nxt = {cur[WIDTH-2:0], ~cur[WIDTH-1]};
                else     nxt = {~cur[0], cur[WIDTH-1:1]};
            end
            MODE_LFSR: begin
                nxt = {^(cur & TAPS), cur[WIDTH-1:1]};
            end
            MODE_HOLD: begin
                nxt = cur;
            end
            default: begin
                nxt = cur;
            end
        endcase
    end

endmodule : shift_next_state
`default_nettype wire

// File: rtl/modal_shift_counter.sv
`default_nettype none
//==============================================================================
// Module      : modal_shift_counter
// Description : Ring / Johnson / LFSR shift counter with load, lock-up
//               recovery, wrap detection against a seed and period measurement.
// Revision    : 1.0 - initial release
//==============================================================================
module modal_shift_counter
    import modal_shift_counter_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b0011),
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(4'b1000)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    input  logic [1:0]          mode,
    input  logic                dir,
    output logic [WIDTH-1:0]    out,
    output logic                wrap,
    output logic                lockup,
    output logic [PERIOD_W-1:0] period
);

    // Elaboration-time guards on the parameter set
    if (WIDTH < 3 || WIDTH > 32) begin : g_width_check
        $error("modal_shift_counter: WIDTH must be in 3..32");
    end
    if (INIT == '0 || INIT == '1) begin : g_init_check
        $error("modal_shift_counter: INIT must be neither all-zeros nor all-ones");
    end

    logic [WIDTH-1:0]    seed;
    logic [PERIOD_W-1:0] step_cnt;
    logic [WIDTH-1:0]    nxt;
    logic                step_ok;

    shift_next_state #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .cur   (out),
        .mode  (mode),
        .dir   (dir),
        .nxt   (nxt)
    );

    // Flag states that map onto themselves in the current mode
    always_comb begin
        lockup = 1'b0;
        if (mode == MODE_LFSR && out == '0)
            lockup = 1'b1;
        else if (mode == MODE_RING && (out == '0 || out == '1))
            lockup = 1'b1;
    end

    // A real step happens only when enabled and not in hold
    always_comb begin
        step_ok = en && (mode != MODE_HOLD);
    end

    // State, seed and counters: load beats recovery beats step beats hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out      <= INIT;
            seed     <= INIT;
            step_cnt <= '0;
            period   <= '0;
            wrap     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                out      <= load_val;
                seed     <= load_val;
                step_cnt <= '0;
            end else if (en && lockup) begin
                // Escape a stuck state by restarting from the seed constant
                out      <= INIT;
                seed     <= INIT;
                step_cnt <= '0;
            end else if (step_ok) begin
                out <= nxt;
                if (nxt == seed) begin
                    wrap     <= 1'b1;
                    period   <= sat_inc(step_cnt);
                    step_cnt <= '0;
                end else begin
                    step_cnt <= sat_inc(step_cnt);
                end
            end
        end
    end

endmodule : modal_shift_counter
`default_nettype wire

// File: tb/tb_modal_shift_counter.sv
`default_nettype none
//==============================================================================
// Module      : tb_modal_shift_counter
// Description : Directed self-checking bench for modal_shift_counter (W=4).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
module tb_modal_shift_counter;

    logic        clk;
    logic        reset;
    logic        en;
    logic        load;
    logic [3:0]  load_val;
    logic [1:0]  mode;
    logic        dir;
    logic [3:0]  out;
    logic        wrap;
    logic        lockup;
    logic [15:0] period;

    int checks;
    int errors;

    modal_shift_counter #(
        .WIDTH (4),
        .TAPS  (4'b0011),
        .INIT  (4'b1000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .dir      (dir),
        .out      (out),
        .wrap     (wrap),
        .lockup   (lockup),
        .period   (period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] lfsr_exp [15];
    logic [3:0] ring_r   [4];
    logic [3:0] ring_l   [4];
    logic [3:0] john_exp [8];

    initial begin
        checks = 0;
        errors = 0;
        lfsr_exp = '{4'b0100, 4'b0010, 4'b1001, 4'b1100, 4'b0110,
                     4'b1011, 4'b0101, 4'b1010, 4'b1101, 4'b1110,
                     4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b1000};
        ring_r   = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        ring_l   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        john_exp = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                     4'b0111, 4'b0011, 4'b0001, 4'b0000};

        reset    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        load_val = 4'b0000;
        mode     = 2'b10;
        dir      = 1'b0;
        #12;
        check("rst_out",    32'(out),    32'h8);
        check("rst_wrap",   32'(wrap),   32'h0);
        check("rst_period", 32'(period), 32'h0);
        check("rst_lockup", 32'(lockup), 32'h0);
        reset = 1'b1;
        #2;

        // LFSR full cycle from INIT
        en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("lfsr_out%0d", i + 1), 32'(out), 32'(lfsr_exp[i]));
            check($sformatf("lfsr_wrap%0d", i + 1), 32'(wrap), (i == 14) ? 32'h1 : 32'h0);
        end
        check("lfsr_period", 32'(period), 32'd15);

        // Ring right then left from 0001
        en = 1'b0; mode = 2'b00; load = 1'b1; load_val = 4'b0001;
        tick();
        check("ring_load", 32'(out), 32'h1);
        check("ring_load_wrap", 32'(wrap), 32'h0);
        load = 1'b0; en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("ringR_out%0d", i + 1), 32'(out), 32'(ring_r[i]));
            check($sformatf("ringR_wrap%0d", i + 1), 32'(wrap), (i == 3) ? 32'h1 : 32'h0);
        end
        check("ringR_period", 32'(period), 32'd4);
        dir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("ringL_out%0d", i + 1), 32'(out), 32'(ring_l[i]));
            check($sformatf("ringL_wrap%0d", i + 1), 32'(wrap), (i == 3) ? 32'h1 : 32'h0);
        end
        check("ringL_period", 32'(period), 32'd4);

        // Johnson right from 0000: no lockup, period 8
        en = 1'b0; dir = 1'b0; mode = 2'b01; load = 1'b1; load_val = 4'b0000;
        tick();
        check("john_lockup0", 32'(lockup), 32'h0);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("john_out%0d", i + 1), 32'(out), 32'(john_exp[i]));
            check($sformatf("john_wrap%0d", i + 1), 32'(wrap), (i == 7) ? 32'h1 : 32'h0);
            check($sformatf("john_lock%0d", i + 1), 32'(lockup), 32'h0);
        end
        check("john_period", 32'(period), 32'd8);

        // LFSR lock-up and recovery
        en = 1'b0; mode = 2'b10; load = 1'b1; load_val = 4'b0000;
        tick();
        load = 1'b0;
        check("lfsr_lock", 32'(lockup), 32'h1);
        tick();
        check("lfsr_lock_hold", 32'(out), 32'h0);
        en = 1'b1;
        tick();
        check("recov_out", 32'(out), 32'h8);
        check("recov_lock", 32'(lockup), 32'h0);
        check("recov_period", 32'(period), 32'd8);
        check("recov_wrap", 32'(wrap), 32'h0);

        // Ring all-ones is stuck; hold mode never flags
        en = 1'b0; mode = 2'b00; load = 1'b1; load_val = 4'b1111;
        tick();
        load = 1'b0;
        check("ring_ones_lock", 32'(lockup), 32'h1);
        mode = 2'b11; en = 1'b1;
        #1;
        check("hold_lock", 32'(lockup), 32'h0);
        tick();
        check("hold_out", 32'(out), 32'hF);

        // Load with en together, then async reset mid-sequence
        mode = 2'b00; dir = 1'b0; load = 1'b1; en = 1'b1; load_val = 4'b0110;
        tick();
        check("load_en_out", 32'(out), 32'h6);
        check("load_en_wrap", 32'(wrap), 32'h0);
        load = 1'b0;
        tick();
        check("post_load1", 32'(out), 32'h3);
        tick();
        check("post_load2", 32'(out), 32'h9);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 32'h8);
        check("async_rst_period", 32'(period), 32'h0);
        check("async_rst_wrap", 32'(wrap), 32'h0);
        reset = 1'b1;
        tick();
        check("first_step", 32'(out), 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_modal_shift_counter
`default_nettype wire
